// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch (inst) and load/store (data) ports.
// One outstanding transaction; cancelled fetch responses are consumed silently.
module sram_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   drop;

  logic winner_data;
  logic sel_data;
  logic any_req;
  logic grant;
  logic resp;

  assign any_req     = inst_req | data_req;
  assign winner_data = (DATA_PRIO != 0) ? data_req : (data_req & ~inst_req);

  // Once locked or waiting the owner register steers the mux, never the live requests.
  assign sel_data = (state == IDLE) ? winner_data : owner;

  always_comb begin
    bus_req = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    bus_req = any_req;
        LOCK:    bus_req = 1'b1;
        default: bus_req = 1'b0;
      endcase
    end
  end

  assign grant = bus_req & bus_addr_ok;
  assign resp  = ~rst & (state == WAIT) & bus_data_ok;

  assign inst_addr_ok = grant & ~sel_data;
  assign data_addr_ok = grant & sel_data;
  assign data_data_ok = resp & owner;
  assign inst_data_ok = resp & ~owner & ~drop & ~inst_cancel;

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  always_comb begin
    if (sel_data) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else begin
      bus_wr    = 1'b0;
      bus_size  = 2'd2;
      bus_wstrb = '0;
      bus_addr  = inst_addr;
      bus_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      drop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner_data;
            state <= bus_addr_ok ? WAIT : LOCK;
          end
        end
        LOCK: begin
          if (inst_cancel && !owner) drop <= 1'b1;
          if (bus_addr_ok) state <= WAIT;
        end
        WAIT: begin
          if (inst_cancel && !owner) drop <= 1'b1;
          if (bus_data_ok) begin
            state <= IDLE;
            drop  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: transaction-level model checked every cycle
// plus literal expectations pinned at key cycles of each scenario.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        bus_addr_ok, bus_data_ok;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;

  int total = 0;
  int bad   = 0;
  bit run_model = 1'b0;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: who is presenting (-1 none), who is outstanding (-1 none), flushed flag.
  int pend = -1;
  int outst = -1;
  bit flushed = 1'b0;

  always @(negedge clk) begin
    if (run_model) begin
      int who;
      bit e_breq, e_iaok, e_daok, e_idok, e_ddok;
      who = -1;
      e_breq = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
      if (rst) begin
        pend = -1; outst = -1; flushed = 0;
      end else if (outst >= 0) begin
        e_ddok = bus_data_ok && outst == 1;
        e_idok = bus_data_ok && outst == 0 && !flushed && !inst_cancel;
        if (inst_cancel && outst == 0) flushed = 1;
        if (bus_data_ok) begin outst = -1; flushed = 0; end
      end else begin
        if (pend >= 0) who = pend;
        else if (data_req) who = 1;
        else if (inst_req) who = 0;
        e_breq = (who >= 0);
        e_iaok = (who == 0) && bus_addr_ok;
        e_daok = (who == 1) && bus_addr_ok;
        if (inst_cancel && pend == 0) flushed = 1;
        if (who >= 0) begin
          if (bus_addr_ok) begin outst = who; pend = -1; end
          else pend = who;
        end
      end
      check("bus_req", bus_req, e_breq);
      check("inst_addr_ok", inst_addr_ok, e_iaok);
      check("data_addr_ok", data_addr_ok, e_daok);
      check("inst_data_ok", inst_data_ok, e_idok);
      check("data_data_ok", data_data_ok, e_ddok);
      check("inst_rdata", inst_rdata, bus_rdata);
      check("data_rdata", data_rdata, bus_rdata);
      if (e_breq) begin
        check("bus_addr", bus_addr, (who == 1) ? data_addr : inst_addr);
        check("bus_wr", bus_wr, (who == 1) ? data_wr : 1'b0);
        check("bus_size", bus_size, (who == 1) ? data_size : 2'd2);
        check("bus_wstrb", bus_wstrb, (who == 1) ? data_wstrb : 4'h0);
        check("bus_wdata", bus_wdata, (who == 1) ? data_wdata : 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_in();
    inst_req = 0; inst_cancel = 0; data_req = 0; data_wr = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_size = 0; data_wstrb = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    run_model = 1;
    inst_req = 1; data_req = 1; bus_addr_ok = 1;
    at_sample();
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    step();
    rst = 0; clear_in();

    // 1: zero-cycle inst grant, data next cycle
    step();
    inst_req = 1; inst_addr = 32'h1c000000; bus_addr_ok = 1;
    at_sample();
    check("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    check("t1_bus_addr", bus_addr, 32'h1c000000);
    step();
    clear_in(); bus_data_ok = 1; bus_rdata = 32'h02800000;
    at_sample();
    check("t1_inst_data_ok", inst_data_ok, 1'b1);
    check("t1_inst_rdata", inst_rdata, 32'h02800000);
    step(); clear_in();

    // 2: simultaneous requests, data wins
    inst_req = 1; inst_addr = 32'h200; data_req = 1; data_addr = 32'h100; bus_addr_ok = 1;
    at_sample();
    check("t2_bus_addr", bus_addr, 32'h100);
    check("t2_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
    step();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11;
    at_sample();
    check("t2_data_data_ok", data_data_ok, 1'b1);
    check("t2_inst_wait", inst_addr_ok, 1'b0);
    step();
    bus_data_ok = 0; bus_addr_ok = 1;
    at_sample();
    check("t2_inst_addr_ok", inst_addr_ok, 1'b1);
    step();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h22;
    step(); clear_in();

    // 3: LOCK holds inst against later data request
    inst_req = 1; inst_addr = 32'h300;
    step();
    data_req = 1; data_addr = 32'h400; data_wr = 0; data_size = 2'd1;
    at_sample();
    check("t3_lock_addr", bus_addr, 32'h300);
    step();
    step();
    bus_addr_ok = 1;
    at_sample();
    check("t3_grant", {data_addr_ok, inst_addr_ok}, 2'b01);
    step();
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h33;
    step();
    bus_data_ok = 0; bus_addr_ok = 1;
    at_sample();
    check("t3_data_addr_ok", data_addr_ok, 1'b1);
    check("t3_data_size", bus_size, 2'd1);
    step();
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h44;
    at_sample();
    check("t3_data_data_ok", data_data_ok, 1'b1);
    step(); clear_in();

    // 4: cancel during WAIT, then normal fetch
    inst_req = 1; inst_addr = 32'h500; bus_addr_ok = 1;
    step();
    clear_in(); inst_cancel = 1;
    step();
    inst_cancel = 0; bus_data_ok = 1; bus_rdata = 32'h55;
    at_sample();
    check("t4_dropped", inst_data_ok, 1'b0);
    step(); clear_in();
    inst_req = 1; inst_addr = 32'h504; bus_addr_ok = 1;
    step();
    clear_in(); bus_data_ok = 1; bus_rdata = 32'h66;
    at_sample();
    check("t4_forwarded", inst_data_ok, 1'b1);
    step(); clear_in();

    // 4b: cancel in IDLE is ignored, cancel in LOCK keeps bus_req and drops data
    inst_req = 1; inst_addr = 32'h600; inst_cancel = 1;
    step();
    at_sample();
    check("t4b_lock_req", bus_req, 1'b1);
    step();
    inst_cancel = 0; bus_addr_ok = 1;
    step();
    clear_in(); bus_data_ok = 1; bus_rdata = 32'h77;
    at_sample();
    check("t4b_dropped", inst_data_ok, 1'b0);
    step(); clear_in();

    // 4c: cancel coincident with data_ok
    inst_req = 1; inst_addr = 32'h700; bus_addr_ok = 1;
    step();
    clear_in(); bus_data_ok = 1; inst_cancel = 1; bus_rdata = 32'h88;
    at_sample();
    check("t4c_dropped", inst_data_ok, 1'b0);
    step(); clear_in();

    // 5: store mirrored onto the bus; stray data_ok in IDLE ignored
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h8000; data_wdata = 32'hdeadbeef; bus_addr_ok = 1;
    at_sample();
    check("t5_bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
          {1'b1, 2'd2, 4'hf, 32'h8000, 32'hdeadbeef});
    step();
    clear_in(); bus_data_ok = 1;
    at_sample();
    check("t5_data_data_ok", data_data_ok, 1'b1);
    step();
    at_sample();
    check("t5_pulse_end", data_data_ok, 1'b0);
    step(); clear_in();

    // 6: reset in WAIT with pending drop
    inst_req = 1; inst_addr = 32'h900; bus_addr_ok = 1;
    step();
    clear_in(); inst_cancel = 1;
    step();
    clear_in(); rst = 1; bus_data_ok = 1; data_req = 1;
    at_sample();
    check("t6_rst_req", bus_req, 1'b0);
    check("t6_rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    step();
    rst = 0; clear_in();
    inst_req = 1; inst_addr = 32'h904; bus_addr_ok = 1;
    at_sample();
    check("t6_idle_grant", inst_addr_ok, 1'b1);
    step();
    clear_in(); bus_data_ok = 1; bus_rdata = 32'h99;
    at_sample();
    check("t6_drop_cleared", inst_data_ok, 1'b1);
    step(); clear_in();
    step();

    run_model = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
